// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit: 32-step shift-add multiplier and restoring divider with PC stall.
// Optional MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic        sign_a_q, sign_a_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        q_bit;
    logic        mul_early;
    logic        last_iter;

    assign a_neg = op[0] & a[31];
    assign b_neg = op[0] & b[31];
    assign a_mag = a_neg ? (~a + 32'd1) : a;
    assign b_mag = b_neg ? (~b + 32'd1) : b;

    // Divide step: acc holds {rem, quot}; the shifted remainder needs 33 bits for the trial compare.
    assign rem_sh  = acc_q[63:31];
    assign q_bit   = (rem_sh >= {1'b0, mcand_q[31:0]});
    assign rem_sub = rem_sh[31:0] - mcand_q[31:0];

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_early = ~op_q[1] & (mplier_q[31:1] == 31'd0);
`else
    assign mul_early = 1'b0;
`endif
    assign last_iter = (cnt_q == 6'd31);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    neg_d    = a_neg ^ b_neg;
                    sign_a_d = a_neg;
                    cnt_d    = 6'd0;
                    dz_d     = 1'b0;
                    if (op[1]) begin
                        acc_d    = {32'd0, a_mag};
                        mcand_d  = {32'd0, b_mag};
                        mplier_d = 32'd0;
                        if (b == 32'd0) begin
                            hi_d    = a;
                            lo_d    = 32'hFFFF_FFFF;
                            dz_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end else begin
                        acc_d    = 64'd0;
                        mcand_d  = {32'd0, a_mag};
                        mplier_d = b_mag;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (op_q[1]) begin
                    acc_d = q_bit ? {rem_sub, acc_q[30:0], 1'b1}
                                  : {rem_sh[31:0], acc_q[30:0], 1'b0};
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mplier_d = mplier_q >> 1;
                    mcand_d  = mcand_q << 1;
                end
                if (last_iter || mul_early) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q[1]) begin
                    lo_d = (op_q[0] & neg_q)    ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
                    hi_d = (op_q[0] & sign_a_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                end else begin
                    {hi_d, lo_d} = (op_q[0] & neg_q) ? (~acc_q + 64'd1) : acc_q;
                end
                state_d = DONE;
            end
            DONE: begin
                // The instruction that issued this op is still present; its start is ignored.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            cnt_q    <= 6'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
        end
    end

    assign stall    = ~reset & (((state_q == IDLE) & start) | (state_q == CALC) | (state_q == FIX));
    assign done     = (state_q == DONE);
    assign div_zero = done & dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed spec vectors, random ops vs arithmetic model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        stall, done, div_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .stall(stall), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    // Reference result {div_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 2'd0) begin
            p = {32'd0, x} * {32'd0, y};
            return {1'b0, p};
        end else if (o == 2'd1) begin
            p = 64'(sx * sy);
            return {1'b0, p};
        end else if (y == 32'd0) begin
            return {1'b1, x, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
            return {1'b0, x % y, x / y};
        end else begin
            q = sx / sy;
            r = sx % sy;
            return {1'b0, r[31:0], q[31:0]};
        end
    endfunction

    // Expected cycle index of the done pulse (start cycle = 0).
    function automatic int model_lat(input logic [1:0] o, input logic [31:0] y);
        logic [31:0] m;
        int n;
        if (o[1] && y == 32'd0) return 1;
        if (o[1]) return 34;
        m = (o[0] && y[31]) ? -y : y;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        if (n == 0) n = 1;
`ifdef MULDIV_EARLY_OUT_EN
        return n + 2;
`else
        return 34;
`endif
    endfunction

    // Issues one op in the current (IDLE) cycle and observes it until done; perturbs operands mid-op.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold,
                          output int dcyc, output bit stall_ok,
                          output logic [31:0] h, output logic [31:0] l, output logic dz);
        int exp_lat;
        exp_lat = model_lat(o, y);
        start = 1'b1; op = o; a = x; b = y;
        dcyc = -1; stall_ok = 1'b1; h = 32'd0; l = 32'd0; dz = 1'b0;
        #1;
        if (stall !== 1'b1) stall_ok = 1'b0;
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            @(posedge clk); #1;
            if (stall !== (c < exp_lat)) stall_ok = 1'b0;
            if (done === 1'b1) begin
                dcyc = c; h = hi; l = lo; dz = div_zero;
            end
            op = 2'($urandom); a = $urandom; b = $urandom;
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 2'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
        n_checks++;
        if ({done, div_zero, hi, lo} !== 66'd0)
            begin n_fail++; $display("FAIL reset_outputs got done=%b dz=%b hi=%h lo=%h want all 0", done, div_zero, hi, lo); end
        start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_quiet got stall=%b done=%b want 0 0", stall, done); end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [7] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd1, 2'd3};
        logic [31:0] t_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'd100, 32'h80000000, 32'd7};
        logic [31:0] t_b  [7] = '{32'hFFFFFFFF, 32'd6, 32'd2, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'hFFFFFFFE};
        logic [31:0] t_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd2, 32'h40000000, 32'd1};
        logic [31:0] t_lo [7] = '{32'h00000001, 32'hFFFFFFD6, 32'hFFFFFFFD, 32'h80000000, 32'd14, 32'd0, 32'hFFFFFFFD};
        int dcyc, lat; bit sok; logic [31:0] h, l; logic dz;
        for (int i = 0; i < 7; i++) begin
            lat = model_lat(t_op[i], t_b[i]);
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, dcyc, sok, h, l, dz);
            n_checks++;
            if (dcyc != lat) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, dcyc, lat); end
            n_checks++;
            if (!sok) begin n_fail++; $display("FAIL dir%0d_stall got mismatching stall profile want high cycles 0..%0d", i, lat - 1); end
            n_checks++;
            if (h !== t_hi[i] || l !== t_lo[i] || dz !== 1'b0)
                begin n_fail++; $display("FAIL dir%0d_result got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=0", i, h, l, dz, t_hi[i], t_lo[i]); end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pulse got done=%b want 0 after DONE", i, done); end
            $display("directed %0d: op=%0d a=%h b=%h -> hi=%h lo=%h at cycle %0d", i, t_op[i], t_a[i], t_b[i], h, l, dcyc);
        end
    endtask

    task automatic test_div_zero();
        logic [1:0]  t_op [2] = '{2'd2, 2'd3};
        logic [31:0] t_a  [2] = '{32'd100, 32'hFFFFFFFB};
        int dcyc; bit sok; logic [31:0] h, l; logic dz;
        for (int i = 0; i < 2; i++) begin
            run_op(t_op[i], t_a[i], 32'd0, 1'b0, dcyc, sok, h, l, dz);
            n_checks++;
            if (dcyc != 1 || !sok) begin n_fail++; $display("FAIL dz%0d_timing got done cycle %0d stall_ok=%b want 1 1", i, dcyc, sok); end
            n_checks++;
            if (dz !== 1'b1 || l !== 32'hFFFFFFFF || h !== t_a[i])
                begin n_fail++; $display("FAIL dz%0d_result got dz=%b hi=%h lo=%h want dz=1 hi=%h lo=ffffffff", i, dz, h, l, t_a[i]); end
            @(posedge clk); #1;
            n_checks++;
            if (div_zero !== 1'b0 || h !== hi) begin n_fail++; $display("FAIL dz%0d_after got div_zero=%b hi=%h want 0 %h", i, div_zero, hi, h); end
            $display("div_zero %0d: a=%h -> hi=%h lo=%h dz=%b", i, t_a[i], h, l, dz);
        end
    endtask

    task automatic test_random();
        logic [31:0] corners [5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [1:0] o; logic [31:0] x, y; logic [64:0] exp_r;
        int dcyc, lat; bit sok; logic [31:0] h, l; logic dz;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : ($urandom >> $urandom_range(0, 31));
            exp_r = model(o, x, y);
            lat = model_lat(o, y);
            run_op(o, x, y, 1'b0, dcyc, sok, h, l, dz);
            n_checks++;
            if (dcyc != lat || !sok) begin n_fail++; $display("FAIL rnd%0d_timing got done cycle %0d stall_ok=%b want %0d 1", i, dcyc, sok, lat); end
            n_checks++;
            if ({dz, h, l} !== exp_r)
                begin n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                                         i, o, x, y, dz, h, l, exp_r[64], exp_r[63:32], exp_r[31:0]); end
            @(posedge clk); #1;
            $display("random %0d: op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b cycle %0d", i, o, x, y, h, l, dz, dcyc);
        end
    endtask

    task automatic test_back_to_back();
        int dcyc, lat; bit sok; logic [31:0] h, l; logic dz;
        lat = model_lat(2'd0, 32'd3);
        run_op(2'd0, 32'd5, 32'd3, 1'b1, dcyc, sok, h, l, dz);
        n_checks++;
        if (dcyc != lat || h !== 32'd0 || l !== 32'd15)
            begin n_fail++; $display("FAIL b2b_first got cycle %0d hi=%h lo=%h want %0d 0 f", dcyc, h, l, lat); end
        @(posedge clk); #1;
        n_checks++;
        if (stall !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart got stall=%b done=%b want 1 0", stall, done); end
        run_op(2'd2, 32'd9, 32'd2, 1'b0, dcyc, sok, h, l, dz);
        n_checks++;
        if (dcyc != 34 || !sok || h !== 32'd1 || l !== 32'd4)
            begin n_fail++; $display("FAIL b2b_second got cycle %0d stall_ok=%b hi=%h lo=%h want 34 1 1 4", dcyc, sok, h, l); end
        @(posedge clk); #1;
        $display("back_to_back: 5*3 then 9/2 -> hi=%h lo=%h", h, l);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        int dcyc; bit sok; logic [31:0] h, l; logic dz;
        start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; end
        reset = 1'b1; #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall got %b want 0 during reset", stall); end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        #1;
        n_checks++;
        if ({done, div_zero, stall, hi, lo} !== 67'd0)
            begin n_fail++; $display("FAIL abort_clear got done=%b dz=%b stall=%b hi=%h lo=%h want all 0", done, div_zero, stall, hi, lo); end
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1'b1; end
        n_checks++;
        if (saw_done) begin n_fail++; $display("FAIL abort_no_done got done pulse want none"); end
        run_op(2'd2, 32'd100, 32'd7, 1'b0, dcyc, sok, h, l, dz);
        n_checks++;
        if (dcyc != 34 || h !== 32'd2 || l !== 32'd14)
            begin n_fail++; $display("FAIL abort_fresh got cycle %0d hi=%h lo=%h want 34 2 e", dcyc, h, l); end
        @(posedge clk); #1;
        $display("reset_abort: fresh 100/7 -> hi=%h lo=%h", h, l);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
